// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: scoreboard-based RAW stalls, MEM-stage redirect flushes.
// Optional HAZ_PERF_CNT_EN adds perf_stall/perf_flush event counters.
module pipe_hazard_cmp (
    input  logic       en,
    input  logic       sb_vld,
    input  logic [4:0] sb_rd,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    output logic       hit
);
    assign hit = en && sb_vld &&
                 ((id_uses_rs && (sb_rd == id_rs)) || (id_uses_rt && (sb_rd == id_rt)));
endmodule

module pipe_hazard_ctrl #(
    parameter int WB_BYPASS = 0,
    parameter int MAX_STALL = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_reg_write,
    input  logic [4:0]  id_wr_reg,
    input  logic        mem_branch,
    input  logic        mem_zf,
    input  logic        mem_jump,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic [1:0]  state,
    output logic [1:0]  stall_cnt,
    output logic        stall_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0] perf_stall,
    output logic [15:0] perf_flush
`endif
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} act_e;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
    } sb_entry_t;

    localparam sb_entry_t  NO_ENT = '0;
    localparam logic [1:0] MAX_L  = 2'(MAX_STALL);

    // sb[0]=EX, sb[1]=MEM, sb[2]=WB
    sb_entry_t [2:0] sb;
    sb_entry_t       ex_new;
    logic      [2:0] hit;
    logic            hazard;
    logic            redirect;
    act_e            act;
    act_e            state_q;

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_cmp
            pipe_hazard_cmp u_cmp (
                .en         ((i != 2) || (WB_BYPASS == 0)),
                .sb_vld     (sb[i].vld),
                .sb_rd      (sb[i].rd),
                .id_rs      (id_rs),
                .id_rt      (id_rt),
                .id_uses_rs (id_uses_rs),
                .id_uses_rt (id_uses_rt),
                .hit        (hit[i])
            );
        end
    endgenerate

    assign hazard   = |hit;
    assign redirect = (mem_branch & mem_zf) | mem_jump;
    assign ex_new   = '{vld: id_reg_write && (id_wr_reg != 5'd0), rd: id_wr_reg};
    assign state    = state_q;

    // Held in RUN while reset is asserted so no flush/bubble leaks out during reset.
    always_comb begin
        act          = RUN;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        if (rst_n) begin
            if (redirect)    act = FLUSH;
            else if (hazard) act = STALL;
        end
        unique case (act)
            FLUSH: begin
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                exmem_bubble = 1'b1;
            end
            STALL: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= act;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb        <= {NO_ENT, NO_ENT, NO_ENT};
            stall_cnt <= 2'd0;
            stall_err <= 1'b0;
        end else begin
            unique case (act)
                STALL: begin
                    sb <= {sb[1], sb[0], NO_ENT};
                    if (stall_cnt != 2'd3) stall_cnt <= stall_cnt + 2'd1;
                    if (stall_cnt == MAX_L) stall_err <= 1'b1;
                end
                FLUSH: begin
                    sb        <= {sb[1], NO_ENT, NO_ENT};
                    stall_cnt <= 2'd0;
                end
                default: begin
                    sb        <= {sb[1], sb[0], ex_new};
                    stall_cnt <= 2'd0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= 16'd0;
            perf_flush <= 16'd0;
        end else begin
            if (act == STALL) perf_stall <= perf_stall + 16'd1;
            if (act == FLUSH) perf_flush <= perf_flush + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for the main stream plus hand sequences for
// bypass, watchdog, reset-mid-stall and (with HAZ_PERF_CNT_EN) the perf counters.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_wr_reg = '0;
    logic       id_uses_rs = 0, id_uses_rt = 0, id_reg_write = 0;
    logic       mem_branch = 0, mem_zf = 0, mem_jump = 0;

    logic       pc_en, ifid_en, ifid_flush, idex_bubble, exmem_bubble, stall_err;
    logic [1:0] state, stall_cnt;
    logic       pc_en_b, ifid_en_b, ifid_flush_b, idex_bubble_b, exmem_bubble_b, stall_err_b;
    logic [1:0] state_b, stall_cnt_b;
    logic       pc_en_w, ifid_en_w, ifid_flush_w, idex_bubble_w, exmem_bubble_w, stall_err_w;
    logic [1:0] state_w, stall_cnt_w;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] perf_stall, perf_flush, perf_stall_b, perf_flush_b, perf_stall_w, perf_flush_w;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_wr_reg(id_wr_reg),
        .mem_branch(mem_branch), .mem_zf(mem_zf), .mem_jump(mem_jump), .pc_en(pc_en),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .exmem_bubble(exmem_bubble), .state(state), .stall_cnt(stall_cnt), .stall_err(stall_err)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    pipe_hazard_ctrl #(.WB_BYPASS(1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_wr_reg(id_wr_reg),
        .mem_branch(mem_branch), .mem_zf(mem_zf), .mem_jump(mem_jump), .pc_en(pc_en_b),
        .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b),
        .exmem_bubble(exmem_bubble_b), .state(state_b), .stall_cnt(stall_cnt_b), .stall_err(stall_err_b)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall(perf_stall_b), .perf_flush(perf_flush_b)
`endif
    );

    // Watchdog limit lowered so a legal 3-cycle stall trips stall_err
    pipe_hazard_ctrl #(.MAX_STALL(2)) dut_wd (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_wr_reg(id_wr_reg),
        .mem_branch(mem_branch), .mem_zf(mem_zf), .mem_jump(mem_jump), .pc_en(pc_en_w),
        .ifid_en(ifid_en_w), .ifid_flush(ifid_flush_w), .idex_bubble(idex_bubble_w),
        .exmem_bubble(exmem_bubble_w), .state(state_w), .stall_cnt(stall_cnt_w), .stall_err(stall_err_w)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall(perf_stall_w), .perf_flush(perf_flush_w)
`endif
    );

    logic [4:0] outs;
    assign outs = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_bubble};

    localparam logic [4:0] O_RUN = 5'b11000, O_STL = 5'b00010, O_FL = 5'b11111;
    localparam logic [1:0] S_RUN = 2'd0, S_STL = 2'd1, S_FL = 2'd2;

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt, rw;
        logic [4:0] wr;
        logic       br, zf, jmp;
        logic [4:0] exp_o;
        logic [1:0] exp_st, exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   cmps = 0;
    int   errs = 0;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                input logic urt, input logic rw, input logic [4:0] wr,
                                input logic br, input logic zf, input logic jmp,
                                input logic [4:0] eo, input logic [1:0] st, input logic [1:0] cnt);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.rw = rw; v.wr = wr;
        v.br = br; v.zf = zf; v.jmp = jmp; v.exp_o = eo; v.exp_st = st; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        cmps++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic rw, input logic [4:0] wr);
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt; id_reg_write = rw; id_wr_reg = wr;
    endtask

    task automatic set_mem(input logic br, input logic zf, input logic jmp);
        mem_branch = br; mem_zf = zf; mem_jump = jmp;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        set_id(v.rs, v.rt, v.urs, v.urt, v.rw, v.wr);
        set_mem(v.br, v.zf, v.jmp);
        #1;
        chk($sformatf("v%0d_outs", idx), 32'(outs), 32'(v.exp_o));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_state", idx), 32'(state), 32'(v.exp_st));
        chk($sformatf("v%0d_cnt", idx), 32'(stall_cnt), 32'(v.exp_cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_id(0, 0, 0, 0, 0, 0);
        set_mem(0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Independent stream
        vecs.push_back(mk(1, 2, 1, 1, 1, 3, 0, 0, 0, O_RUN, S_RUN, 0));
        vecs.push_back(mk(4, 5, 1, 1, 1, 6, 0, 0, 0, O_RUN, S_RUN, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, S_RUN, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, S_RUN, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, S_RUN, 0));
        // add $3,$1,$2 ; sub $4,$3,$1 -> 3 stalls
        vecs.push_back(mk(1, 2, 1, 1, 1, 3, 0, 0, 0, O_RUN, S_RUN, 0));
        vecs.push_back(mk(3, 1, 1, 1, 1, 4, 0, 0, 0, O_STL, S_STL, 1));
        vecs.push_back(mk(3, 1, 1, 1, 1, 4, 0, 0, 0, O_STL, S_STL, 2));
        vecs.push_back(mk(3, 1, 1, 1, 1, 4, 0, 0, 0, O_STL, S_STL, 3));
        vecs.push_back(mk(3, 1, 1, 1, 1, 4, 0, 0, 0, O_RUN, S_RUN, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, S_RUN, 0));
        // add $0,$1,$2 ; add $5,$0,$0
        vecs.push_back(mk(1, 2, 1, 1, 1, 0, 0, 0, 0, O_RUN, S_RUN, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 5, 0, 0, 0, O_RUN, S_RUN, 0));
        // taken beq in MEM while ID depends on $5 in EX
        vecs.push_back(mk(5, 5, 1, 1, 1, 7, 1, 1, 0, O_FL, S_FL, 0));
        // stall interrupted by a jump, then WB keeps the MEM entry
        vecs.push_back(mk(1, 2, 1, 1, 1, 8, 0, 0, 0, O_RUN, S_RUN, 0));
        vecs.push_back(mk(8, 8, 1, 1, 1, 9, 0, 0, 0, O_STL, S_STL, 1));
        vecs.push_back(mk(8, 8, 1, 1, 1, 9, 0, 0, 1, O_FL, S_FL, 0));
        vecs.push_back(mk(8, 1, 1, 1, 1, 10, 0, 0, 0, O_STL, S_STL, 1));
        vecs.push_back(mk(8, 1, 1, 1, 1, 10, 0, 0, 0, O_RUN, S_RUN, 0));
        // not-taken branch forms
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_RUN, S_RUN, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_RUN, S_RUN, 0));
        // rt-only hazard from WB, then unused operands ignored
        vecs.push_back(mk(1, 10, 1, 1, 1, 11, 0, 0, 0, O_STL, S_STL, 1));
        vecs.push_back(mk(1, 10, 1, 1, 1, 11, 0, 0, 0, O_RUN, S_RUN, 0));
        vecs.push_back(mk(11, 11, 0, 0, 0, 0, 0, 0, 0, O_RUN, S_RUN, 0));

        #12;
        chk("reset_outs", 32'(outs), 32'(O_RUN));
        chk("reset_state", 32'(state), 32'(S_RUN));
        chk("reset_cnt", 32'(stall_cnt), 0);
        chk("reset_err", 32'(stall_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) apply(vecs[k], k);
        chk("main_err_clear", 32'(stall_err), 0);
        chk("wd_err_set", 32'(stall_err_w), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("wd_err_sticky", 32'(stall_err_w), 1);
        do_reset();
        #1;
        chk("wd_err_reset", 32'(stall_err_w), 0);

        // WB_BYPASS=1: only two stall cycles
        @(negedge clk); set_id(1, 2, 1, 1, 1, 3);
        @(negedge clk); set_id(3, 1, 1, 1, 1, 4);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("byp_pc_en%0d", k), 32'(pc_en_b), (k == 2) ? 1 : 0);
            chk($sformatf("nobyp_pc_en%0d", k), 32'(pc_en), 0);
            @(negedge clk);
        end
        do_reset();

        // reset in the second stall cycle
        @(negedge clk); set_id(1, 2, 1, 1, 1, 3);
        @(negedge clk); set_id(3, 1, 1, 1, 1, 4);
        @(negedge clk);
        #1;
        chk("mid_stall_pc_en", 32'(pc_en), 0);
        chk("mid_stall_cnt", 32'(stall_cnt), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'(outs), 32'(O_RUN));
        chk("async_rst_state", 32'(state), 32'(S_RUN));
        chk("async_rst_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_no_stall", 32'(outs), 32'(O_RUN));
        @(posedge clk);
        #1;
        chk("post_rst_state", 32'(state), 32'(S_RUN));

`ifdef HAZ_PERF_CNT_EN
        do_reset();
        #1;
        chk("perf_rst_stall", 32'(perf_stall), 0);
        chk("perf_rst_flush", 32'(perf_flush), 0);
        @(negedge clk); set_id(1, 2, 1, 1, 1, 3);
        @(negedge clk); set_id(3, 1, 1, 1, 1, 4);
        repeat (4) @(negedge clk);
        set_id(0, 0, 0, 0, 0, 0);
        set_mem(0, 0, 1);
        @(negedge clk);
        set_mem(0, 0, 0);
        #1;
        chk("perf_stall", 32'(perf_stall), 3);
        chk("perf_flush", 32'(perf_flush), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
